// File: rtl/slot_pkg.sv
// Shared types and widths for the slot-machine spin sequencer.
package slot_pkg;

  localparam int unsigned CREDIT_W = 12;
  localparam int unsigned REEL_W   = 3;
  localparam int unsigned FRAME_W  = 10;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StSpin  = 3'd2,
    StCount = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } state_e;

  function automatic logic [FRAME_W-1:0] sat_inc(input logic [FRAME_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spin_sequencer_if.sv
// Spin request handshake: the game logic (master) offers one round, the sequencer accepts it.
interface spin_sequencer_if;
  import slot_pkg::*;

  logic                req_valid;
  logic [REEL_W-1:0]   req_reel1;
  logic [REEL_W-1:0]   req_reel2;
  logic [REEL_W-1:0]   req_reel3;
  logic [CREDIT_W-1:0] req_win;
  logic [CREDIT_W-1:0] req_total;
  logic                req_ready;

  modport master (
    output req_valid, req_reel1, req_reel2, req_reel3, req_win, req_total,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_reel1, req_reel2, req_reel3, req_win, req_total,
    output req_ready
  );

endinterface

// File: rtl/frame_tick_det.sv
// Registered falling-edge detector on active-low vsync; one-cycle frame tick.
module frame_tick_det (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic vsync_ni,
  output logic frame_tick_o
);

  logic vsync_q, vsync_d;
  logic tick_q, tick_d;

  always_comb begin
    vsync_d = vsync_ni;
    tick_d  = vsync_q & ~vsync_ni;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      vsync_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick_o = tick_q;

endmodule

// File: rtl/spin_sequencer.sv
// Round sequencer: accept request, spin reels on frame boundaries, count up credits.
// Optional spin watchdog enabled by defining SPIN_TIMEOUT_EN.
module spin_sequencer
  import slot_pkg::*;
#(
  parameter int unsigned MIN_SPIN_FRAMES = 60,
  parameter int unsigned STEP_FRAMES     = 2,
  parameter int unsigned TIMEOUT_FRAMES  = 600
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vsync,
  spin_sequencer_if.slave     req,
  output logic                spin_start,
  output logic [REEL_W-1:0]   reel1_idx,
  output logic [REEL_W-1:0]   reel2_idx,
  output logic [REEL_W-1:0]   reel3_idx,
  input  logic                spin_done,
  output logic [CREDIT_W-1:0] disp_credits,
  output logic                busy,
  output logic                round_done,
  output logic                timeout_err,
  output logic [2:0]          state_led
);

  localparam logic [FRAME_W-1:0] MinFrames     = FRAME_W'(MIN_SPIN_FRAMES);
  localparam logic [FRAME_W-1:0] StepLast      = FRAME_W'(STEP_FRAMES - 1);
  localparam logic [FRAME_W-1:0] TimeoutFrames = FRAME_W'(TIMEOUT_FRAMES);
`ifdef SPIN_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic frame_tick;

  frame_tick_det u_frame_tick_det (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .vsync_ni     (vsync),
    .frame_tick_o (frame_tick)
  );

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d, frame_nxt;
  logic [FRAME_W-1:0]  step_q, step_d;
  logic [REEL_W-1:0]   reel1_q, reel1_d, reel2_q, reel2_d, reel3_q, reel3_d;
  logic [CREDIT_W-1:0] win_q, win_d, total_q, total_d, disp_q, disp_d;
  logic                spin_start_q, spin_start_d;
  logic                round_done_q, round_done_d;
  logic                timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    frame_nxt     = frame_q;
    step_d        = step_q;
    reel1_d       = reel1_q;
    reel2_d       = reel2_q;
    reel3_d       = reel3_q;
    win_d         = win_q;
    total_d       = total_q;
    disp_d        = disp_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      StIdle: begin
        if (req.req_valid) begin
          reel1_d       = req.req_reel1;
          reel2_d       = req.req_reel2;
          reel3_d       = req.req_reel3;
          win_d         = req.req_win;
          total_d       = req.req_total;
          timeout_err_d = 1'b0;
          state_d       = StArm;
        end
      end
      StArm: begin
        if (frame_tick) begin
          frame_d = '0;
          state_d = StSpin;
        end
      end
      StSpin: begin
        // A tick arriving with spin_done is counted before the exit test.
        frame_nxt = frame_tick ? sat_inc(frame_q) : frame_q;
        frame_d   = frame_nxt;
        if (spin_done && (frame_nxt >= MinFrames)) begin
          step_d  = '0;
          state_d = StCount;
        end else if (TimeoutEn && !spin_done && (frame_nxt >= TimeoutFrames)) begin
          state_d = StErr;
        end
      end
      StCount: begin
        if ((win_q == '0) || (total_q < disp_q)) begin
          disp_d  = total_q;
          state_d = StDone;
        end else if (disp_q == total_q) begin
          state_d = StDone;
        end else if (frame_tick) begin
          if (step_q >= StepLast) begin
            step_d = '0;
            disp_d = disp_q + 1'b1;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      StErr: begin
        timeout_err_d = 1'b1;
        disp_d        = total_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase

    spin_start_d = (state_d == StSpin);
    round_done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      frame_q       <= '0;
      step_q        <= '0;
      reel1_q       <= '0;
      reel2_q       <= '0;
      reel3_q       <= '0;
      win_q         <= '0;
      total_q       <= '0;
      disp_q        <= '0;
      spin_start_q  <= 1'b0;
      round_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      step_q        <= step_d;
      reel1_q       <= reel1_d;
      reel2_q       <= reel2_d;
      reel3_q       <= reel3_d;
      win_q         <= win_d;
      total_q       <= total_d;
      disp_q        <= disp_d;
      spin_start_q  <= spin_start_d;
      round_done_q  <= round_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req.req_ready  = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign state_led      = state_q;
  assign spin_start     = spin_start_q;
  assign round_done     = round_done_q;
  assign reel1_idx      = reel1_q;
  assign reel2_idx      = reel2_q;
  assign reel3_idx      = reel3_q;
  assign disp_credits   = disp_q;
  assign timeout_err    = TimeoutEn ? timeout_err_q : 1'b0;

endmodule

// File: tb/tb_spin_sequencer.sv
// Self-checking bench for spin_sequencer: directed rounds plus randomized rounds
// checked against a frame-level model of the round rules.
module tb_spin_sequencer;

  localparam int MIN   = 60;
  localparam int STEP  = 2;
  localparam int TMO   = 600;
  localparam int LIMIT = 4000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vsync;
  logic        spin_done;
  logic        spin_start, busy, round_done, timeout_err;
  logic [2:0]  reel1_idx, reel2_idx, reel3_idx, state_led;
  logic [11:0] disp_credits;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks    = 0;
  int cyc      = 0;
  int tick_cyc = 0;
  int model_disp;
  bit vs_prev  = 1'b1;

  spin_sequencer_if req_if ();

  spin_sequencer #(
    .MIN_SPIN_FRAMES (MIN),
    .STEP_FRAMES     (STEP),
    .TIMEOUT_FRAMES  (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vsync        (vsync),
    .req          (req_if),
    .spin_start   (spin_start),
    .reel1_idx    (reel1_idx),
    .reel2_idx    (reel2_idx),
    .reel3_idx    (reel3_idx),
    .spin_done    (spin_done),
    .disp_credits (disp_credits),
    .busy         (busy),
    .round_done   (round_done),
    .timeout_err  (timeout_err),
    .state_led    (state_led)
  );

  always #5 clk = ~clk;

  // Four-cycle frames, vsync low for one cycle.
  initial begin
    int ph = 0;
    vsync = 1'b1;
    forever begin
      @(negedge clk);
      ph++;
      vsync = ((ph % 4) != 0);
    end
  end

  // Frame count as seen on the wire: one per falling vsync sample.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    vs_prev <= vsync;
    if (vs_prev && !vsync) begin
      ticks    <= ticks + 1;
      tick_cyc <= cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue_req(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3,
                           input int win, input int total);
    int n;
    n = 0;
    while (!req_if.req_ready && n < LIMIT) begin @(negedge clk); n++; end
    check("ready_before_req", n < LIMIT, 1);
    req_if.req_valid = 1'b1;
    req_if.req_reel1 = r1;
    req_if.req_reel2 = r2;
    req_if.req_reel3 = r3;
    req_if.req_win   = 12'(win);
    req_if.req_total = 12'(total);
    @(negedge clk);
    req_if.req_valid = 1'b0;
    check("arm_state", state_led, 1);
    check("busy_arm", busy, 1);
    check("ready_low", req_if.req_ready, 0);
    check("reel1", reel1_idx, r1);
    check("reel2", reel2_idx, r2);
    check("reel3", reel3_idx, r3);
    check("tmo_cleared", timeout_err, 0);
  endtask

  task automatic wait_spin(output int spin0);
    int n;
    n = 0;
    while (!spin_start && n < LIMIT) begin @(negedge clk); n++; end
    check("spin_rise", n < LIMIT, 1);
    check("spin_on_frame", cyc - tick_cyc, 1);
    check("spin_state", state_led, 2);
    spin0 = ticks;
  endtask

  task automatic busy_probe(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3);
    req_if.req_valid = 1'b1;
    req_if.req_reel1 = ~r1;
    req_if.req_reel2 = ~r2;
    req_if.req_reel3 = ~r3;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    check("busy_reel1", reel1_idx, r1);
    check("busy_reel3", reel3_idx, r3);
    check("busy_ready", req_if.req_ready, 0);
    check("busy_state", state_led, 2);
  endtask

  task automatic run_spin(input int spin0, input int done_f);
    int n;
    n = 0;
    while (spin_start && n < LIMIT) begin
      if (ticks - spin0 >= done_f) spin_done = 1'b1;
      @(negedge clk);
      n++;
    end
    check("spin_fall", n < LIMIT, 1);
    check("spin_frames", ticks - spin0, (done_f > MIN) ? done_f : MIN);
    check("count_state", state_led, 3);
    spin_done = 1'b0;
  endtask

  task automatic finish_count(input int win, input int total);
    int t0, prev, last, n, pulses;
    t0   = ticks;
    prev = model_disp;
    check("count_entry_disp", disp_credits, prev);
    if (win == 0 || total < prev) begin
      @(negedge clk);
      check("direct_load", disp_credits, total);
      check("done_state", state_led, 4);
      check("done_pulse", round_done, 1);
      @(negedge clk);
      check("idle_after", state_led, 0);
      check("pulse_once", round_done, 0);
    end else begin
      last = prev;
      n    = 0;
      while (disp_credits != 12'(total) && n < LIMIT) begin
        @(negedge clk);
        n++;
        if (disp_credits != 12'(last)) begin
          check("step_inc", disp_credits, last + 1);
          last = int'(disp_credits);
        end
      end
      check("count_end", n < LIMIT, 1);
      check("count_frames", ticks - t0, STEP * (total - prev));
      pulses = 0;
      repeat (3) begin @(negedge clk); pulses += int'(round_done); end
      check("round_done_pulses", pulses, 1);
      check("idle_after", state_led, 0);
      check("ready_idle", req_if.req_ready, 1);
      check("busy_idle", busy, 0);
    end
    model_disp = total;
  endtask

  task automatic do_round(input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] r3,
                          input int win, input int total, input int done_f, input bit probe);
    int s0;
    issue_req(r1, r2, r3, win, total);
    wait_spin(s0);
    if (probe) busy_probe(r1, r2, r3);
    run_spin(s0, done_f);
    finish_count(win, total);
  endtask

  initial begin
    int s0, n, win, total, pulses;
    logic [2:0] a, b, c;
    reset_n          = 1'b0;
    spin_done        = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_reel1 = '0;
    req_if.req_reel2 = '0;
    req_if.req_reel3 = '0;
    req_if.req_win   = '0;
    req_if.req_total = '0;
    repeat (3) @(negedge clk);
    check("rst_state", state_led, 0);
    check("rst_spin", spin_start, 0);
    check("rst_disp", disp_credits, 0);
    check("rst_reel1", reel1_idx, 0);
    check("rst_done", round_done, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_if.req_ready, 1);
    reset_n    = 1'b1;
    model_disp = 0;

    // Set credits to 100, then the basic round 100 -> 105 with a busy probe.
    do_round(3'd0, 3'd0, 3'd0, 0, 100, 65, 1'b0);
    do_round(3'd1, 3'd2, 3'd3, 5, 105, 70, 1'b1);
    // Early spin_done from frame 3: spin held to MIN frames.
    do_round(3'd4, 3'd5, 3'd6, 2, 107, 3, 1'b0);
    // Loss: back to 100 then 50.
    do_round(3'd7, 3'd0, 3'd1, 0, 100, 61, 1'b0);
    do_round(3'd2, 3'd3, 3'd4, 0, 50, 60, 1'b0);

    for (int i = 0; i < 6; i++) begin
      a   = 3'($urandom);
      b   = 3'($urandom);
      c   = 3'($urandom);
      win = $urandom_range(0, 6);
      if (win == 0) total = $urandom_range(0, 300);
      else if ($urandom_range(0, 4) == 0 && model_disp > 0) total = model_disp - 1;
      else total = model_disp + win;
      do_round(a, b, c, win, total, $urandom_range(1, 90), 1'(i % 2));
    end

`ifdef SPIN_TIMEOUT_EN
    total = model_disp + 4;
    issue_req(3'd2, 3'd2, 3'd2, 4, total);
    wait_spin(s0);
    n = 0;
    while (spin_start && n < LIMIT) begin @(negedge clk); n++; end
    check("tmo_fall", n < LIMIT, 1);
    check("tmo_frames", ticks - s0, TMO);
    check("err_state", state_led, 5);
    check("err_no_done", round_done, 0);
    @(negedge clk);
    check("err_idle", state_led, 0);
    check("err_flag", timeout_err, 1);
    check("err_disp", disp_credits, total);
    check("err_no_done2", round_done, 0);
    model_disp = total;
    do_round(3'd5, 3'd5, 3'd5, 1, model_disp + 1, 62, 1'b0);
`else
    do_round(3'd2, 3'd2, 3'd2, 1, model_disp + 1, 620, 1'b0);
    check("no_tmo_flag", timeout_err, 0);
`endif

    // Reset in the middle of the count-up.
    total = model_disp + 10;
    issue_req(3'd6, 3'd6, 3'd6, 10, total);
    wait_spin(s0);
    run_spin(s0, 61);
    n = 0;
    while (int'(disp_credits) < model_disp + 2 && n < LIMIT) begin @(negedge clk); n++; end
    check("mid_count_reached", n < LIMIT, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_state", state_led, 0);
    check("mid_rst_spin", spin_start, 0);
    check("mid_rst_disp", disp_credits, 0);
    check("mid_rst_reel2", reel2_idx, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tmo", timeout_err, 0);
    pulses = int'(round_done);
    repeat (10) begin @(negedge clk); pulses += int'(round_done); end
    check("mid_rst_no_done", pulses, 0);
    check("mid_rst_idle", state_led, 0);
    model_disp = 0;
    do_round(3'd3, 3'd1, 3'd4, 3, 3, 60, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spin_sequencer.md
SPIN_SEQUENCER -- requirements
Module: spin_sequencer

Interface
- Parameters (name, default, meaning):
  - REQ-001 SHALL have MIN_SPIN_FRAMES, 60: minimum frames spin_start is held before done is honoured.
  - REQ-002 SHALL have STEP_FRAMES, 2: frames per +1 credit during count-up.
  - REQ-003 SHALL have TIMEOUT_FRAMES, 600: spin watchdog limit; used only with SPIN_TIMEOUT_EN.
- Ports (name, direction, width, meaning):
  - REQ-004 SHALL have clk, in, 1: single clock (pixel PLL clock); all logic on its rising edge.
  - REQ-005 SHALL have reset_n, in, 1: synchronous, active-low reset.
  - REQ-006 SHALL have vsync, in, 1: active-low VGA vertical sync; its falling edge defines the frame tick.
  - REQ-007 SHALL have req_valid, in, 1: one spin request, sampled while req_ready=1.
  - REQ-008 SHALL have req_reel1, req_reel2, req_reel3, in, 3 each: final sprite indices.
  - REQ-009 SHALL have req_win, in, 12: credits won this round.
  - REQ-010 SHALL have req_total, in, 12: new credit total.
  - REQ-011 SHALL have req_ready, out, 1: high only in IDLE.
  - REQ-012 SHALL have spin_start, out, 1: level start to the sprite memory controller.
  - REQ-013 SHALL have reel1_idx, reel2_idx, reel3_idx, out, 3 each: latched final indices.
  - REQ-014 SHALL have spin_done, in, 1: level "reels stopped" from the memory controller.
  - REQ-015 SHALL have disp_credits, out, 12: displayed credit value.
  - REQ-016 SHALL have busy, out, 1: high in every state except IDLE.
  - REQ-017 SHALL have round_done, out, 1: one-cycle pulse at the end of a round.
  - REQ-018 SHALL have timeout_err, out, 1: sticky watchdog flag.
  - REQ-019 SHALL have state_led, out, 3: current state encoding.

Function
- REQ-020 SHALL produce frame_tick as a one-cycle pulse in the cycle after vsync is sampled 1 then 0 (registered edge detect).
- REQ-021 SHALL implement these states and encodings: IDLE=0, ARM=1, SPIN=2, COUNT=3, DONE=4, ERR=5.
- REQ-022 SHALL drive state_led with the state encoding of REQ-021.
- REQ-023 SHALL, in IDLE, accept req_valid&req_ready by latching reels, req_win and req_total, clearing timeout_err, and moving to ARM on the next cycle.
- REQ-024 SHALL ignore req_valid when req_ready=0: no latch, no queue, no error.
- REQ-025 SHALL leave ARM for SPIN on the first frame_tick, so a spin always begins on a frame boundary.
- REQ-026 SHALL hold spin_start=1 exactly while in SPIN and drop it in the cycle the state is exited.
- REQ-027 SHALL clear an 10-bit saturating frame counter on SPIN entry and increment it on each frame_tick while in SPIN.
- REQ-028 SHALL exit SPIN to COUNT when spin_done=1 and frame count >= MIN_SPIN_FRAMES; an earlier spin_done SHALL be ignored until the count is reached.
- REQ-029 SHALL, in COUNT, load disp_credits directly to the latched total in one cycle and then go to DONE when req_win=0 or the latched total < disp_credits.
- REQ-030 SHALL otherwise, in COUNT, increment disp_credits by 1 every STEP_FRAMES frame_ticks until it equals the latched total, then go to DONE; wrap past 4095 is impossible and needs no handling.
- REQ-031 SHALL pulse round_done for one cycle in DONE and return to IDLE on the next cycle.
- REQ-032 SHALL, when frame_tick and spin_done are true in the same cycle in SPIN, count the tick first and then evaluate the exit condition using the updated count.

Reset
- REQ-033 SHALL, while reset_n=0 at a clk edge, force state=IDLE, spin_start=0, reel*_idx=0, disp_credits=0, round_done=0, timeout_err=0, and the counters to 0.
- REQ-034 SHALL abort any round on reset mid-operation, with spin_start low after the first reset edge and no round_done.

Configuration
- REQ-035 SHALL, with SPIN_TIMEOUT_EN defined, move SPIN to ERR when the frame count reaches TIMEOUT_FRAMES and spin_done is still 0.
- REQ-036 SHALL, in ERR, set timeout_err=1, load disp_credits with the latched total, and return to IDLE next cycle without pulsing round_done.
- REQ-037 SHALL, without SPIN_TIMEOUT_EN, tie timeout_err to 0, never enter ERR, and keep SPIN until spin_done.

Structure
- REQ-038 SHALL take the state enum, CREDIT_W=12 and REEL_W=3 from shared package slot_pkg.
- REQ-039 SHALL instantiate the vsync edge detector as sub-module frame_tick_det.

Verification
- REQ-040 SHALL cover the basic round: request reels 1/2/3, win=5, total 100→105, spin_done at frame 70 → spin_start rises on the first tick, falls at frame 70, disp_credits steps 100..105 every 2 frames, then one round_done pulse.
- REQ-041 SHALL cover early done: spin_done high from frame 3 → spin_start held until frame 60 exactly.
- REQ-042 SHALL cover a loss: win=0, total 50 (previous 100) → disp_credits=50 one cycle after COUNT entry.
- REQ-043 SHALL cover busy rejection: a second req_valid during SPIN → no change to latched reels and req_ready stays 0.
- REQ-044 SHALL cover the timeout with SPIN_TIMEOUT_EN: spin_done never asserts → ERR at frame 600, timeout_err=1, state back to IDLE, and the next request clears timeout_err.
- REQ-045 SHALL cover reset mid-COUNT: reset_n=0 for one cycle → all outputs 0 and state_led=0 next cycle.
